// File: rtl/res_ram_arbiter.sv
// res_ram_arbiter: two-requester arbiter and access sequencer for the single-port result RAM of
// the distance-transform datapath. Requester A is the binary-image loader, requester B the
// forward/backward pass engine. One RAM access per cycle, registered grants and strobes,
// 1-cycle read return to the issuing requester, and burst locking with a MAX_BURST handoff.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   {a,b}_req_i                access request, held until the matching gnt
//   {a,b}_wr_i                 1 = write, 0 = read
//   {a,b}_lock_i               keep ownership after this access
//   {a,b}_addr_i/_wdata_i      pixel address / write data
//   {a,b}_gnt_o                access accepted this cycle
//   {a,b}_rvalid_o/_rdata_o    read return pulse / data held until the next return
//   res_rd_o/res_wr_o          RAM read / write strobes
//   res_addr_o/res_do_o        RAM address / write data (held while idle)
//   res_di_i                   RAM read data
//
// Build option: define RES_ARB_FIXED_PRIO_EN to make idle contention always go to A
// (burst locking and the MAX_BURST handoff still apply).
module res_ram_arbiter #(
  parameter int unsigned AW        = 14,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req_i,
  input  logic          a_wr_i,
  input  logic          a_lock_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  input  logic          b_req_i,
  input  logic          b_wr_i,
  input  logic          b_lock_i,
  input  logic [AW-1:0] b_addr_i,
  input  logic [DW-1:0] b_wdata_i,
  output logic          a_gnt_o,
  output logic          b_gnt_o,
  output logic          a_rvalid_o,
  output logic          b_rvalid_o,
  output logic [DW-1:0] a_rdata_o,
  output logic [DW-1:0] b_rdata_o,
  output logic          res_rd_o,
  output logic          res_wr_o,
  output logic [AW-1:0] res_addr_o,
  output logic [DW-1:0] res_do_o,
  input  logic [DW-1:0] res_di_i
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  // One extra bit so the incremented count never wraps before the compare.
  localparam logic [CntW:0] MaxB = MAX_BURST[CntW:0];

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            favour_b_q, favour_b_d;

  logic            grant_a, grant_b, grant;
  logic            win_wr, win_lock, other_req, force_handoff;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [CntW:0]   grant_num;

  logic            a_gnt_q, b_gnt_q, res_rd_q, res_wr_q;
  logic [AW-1:0]   res_addr_q;
  logic [DW-1:0]   res_do_q;
  logic            a_pend_q, b_pend_q, a_rvalid_q, b_rvalid_q;
  logic [DW-1:0]   a_rdata_q, b_rdata_q;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (a_req_i && b_req_i) begin
          grant_b = favour_b_q;
          grant_a = ~favour_b_q;
        end else begin
          grant_a = a_req_i;
          grant_b = b_req_i;
        end
      end
      StOwnA:  grant_a = a_req_i;
      StOwnB:  grant_b = b_req_i;
      default: ;
    endcase
  end

  always_comb begin
    grant     = grant_a | grant_b;
    win_wr    = grant_b ? b_wr_i    : a_wr_i;
    win_lock  = grant_b ? b_lock_i  : a_lock_i;
    win_addr  = grant_b ? b_addr_i  : a_addr_i;
    win_wdata = grant_b ? b_wdata_i : a_wdata_i;
    other_req = grant_b ? a_req_i   : b_req_i;
    // Grant number within the current burst; a grant from idle starts a new burst.
    grant_num = (state_q == StIdle) ? {{CntW{1'b0}}, 1'b1} : {1'b0, cnt_q} + 1'b1;
    force_handoff = win_lock && other_req && (grant_num >= MaxB);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    favour_b_d = favour_b_q;
    if (state_q != StIdle && state_q != StOwnA && state_q != StOwnB) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
    if (grant) begin
      if (!win_lock || force_handoff) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = grant_b ? StOwnB : StOwnA;
        cnt_d   = (grant_num >= MaxB) ? MaxB[CntW-1:0] : grant_num[CntW-1:0];
      end
`ifdef RES_ARB_FIXED_PRIO_EN
      // A normally wins; B is favoured only right after A is forced off a full burst.
      favour_b_d = grant_a && force_handoff;
`else
      favour_b_d = grant_a;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      favour_b_q <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      favour_b_q <= favour_b_d;
      a_gnt_q    <= grant_a;
      b_gnt_q    <= grant_b;
      res_rd_q   <= grant & ~win_wr;
      res_wr_q   <= grant & win_wr;
      if (grant) begin
        res_addr_q <= win_addr;
        res_do_q   <= win_wdata;
      end
      // Return tag travels with the grant, independent of later ownership changes.
      a_pend_q   <= grant_a & ~a_wr_i;
      b_pend_q   <= grant_b & ~b_wr_i;
      a_rvalid_q <= a_pend_q;
      b_rvalid_q <= b_pend_q;
      if (a_pend_q) a_rdata_q <= res_di_i;
      if (b_pend_q) b_rdata_q <= res_di_i;
    end
  end

  assign a_gnt_o    = a_gnt_q;
  assign b_gnt_o    = b_gnt_q;
  assign res_rd_o   = res_rd_q;
  assign res_wr_o   = res_wr_q;
  assign res_addr_o = res_addr_q;
  assign res_do_o   = res_do_q;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign a_rdata_o  = a_rdata_q;
  assign b_rdata_o  = b_rdata_q;

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Testbench for res_ram_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model of ownership, burst length and memory contents.
module tb_res_ram_arbiter;

  localparam int MAXB = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Requester inputs as arrays: index 0 = A, 1 = B.
  logic        req [2];
  logic        wr  [2];
  logic        lock[2];
  logic [13:0] addr[2];
  logic [7:0]  wdat[2];

  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, res_rd, res_wr;
  logic [7:0]  a_rdata, b_rdata, res_do, res_di;
  logic [13:0] res_addr;

  res_ram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .a_req_i   (req[0]),
    .a_wr_i    (wr[0]),
    .a_lock_i  (lock[0]),
    .a_addr_i  (addr[0]),
    .a_wdata_i (wdat[0]),
    .b_req_i   (req[1]),
    .b_wr_i    (wr[1]),
    .b_lock_i  (lock[1]),
    .b_addr_i  (addr[1]),
    .b_wdata_i (wdat[1]),
    .a_gnt_o   (a_gnt),
    .b_gnt_o   (b_gnt),
    .a_rvalid_o(a_rvalid),
    .b_rvalid_o(b_rvalid),
    .a_rdata_o (a_rdata),
    .b_rdata_o (b_rdata),
    .res_rd_o  (res_rd),
    .res_wr_o  (res_wr),
    .res_addr_o(res_addr),
    .res_do_o  (res_do),
    .res_di_i  (res_di)
  );

  // RAM: writes at posedge, reads at negedge.
  bit [7:0] mem [16384];
  always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;
  always @(negedge clk) if (res_rd) res_di <= mem[res_addr];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit [7:0]    ref_mem [16384];
  int          m_owner;  // -1 none, 0 A, 1 B
  int          m_run;    // grants in current burst
  int          m_pref;   // who wins idle contention
  logic        m_pend  [2];
  logic [7:0]  m_pdata [2];
  logic        m_rvalid[2];
  logic [7:0]  m_rdata [2];
  logic        exp_g   [2];
  logic        exp_rd, exp_wr;
  logic [13:0] m_addr;
  logic [7:0]  m_do;
  int          last_win;  // winner of the most recent cycle, -1 none

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_pref = 0;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_pdata[i] = '0; m_rvalid[i] = 0; m_rdata[i] = '0; exp_g[i] = 0;
    end
    exp_rd = 0; exp_wr = 0; m_addr = '0; m_do = '0;
  endtask

  // Predict the effect of the next clock edge given the currently driven requests.
  task automatic model_step();
    int w, o;
    bit forced;
    w = -1;
    exp_g[0] = 0; exp_g[1] = 0; exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 2; i++) begin
      m_rvalid[i] = m_pend[i];
      if (m_pend[i]) m_rdata[i] = m_pdata[i];
      m_pend[i] = 0;
    end
    if (m_owner >= 0) begin
      if (req[m_owner]) w = m_owner;
    end else if (req[0] && req[1]) w = m_pref;
    else if (req[0]) w = 0;
    else if (req[1]) w = 1;
    last_win = w;
    if (w >= 0) begin
      o = 1 - w;
      exp_g[w] = 1;
      m_addr = addr[w];
      m_do   = wdat[w];
      if (wr[w]) begin
        exp_wr = 1;
        ref_mem[addr[w]] = wdat[w];
      end else begin
        exp_rd = 1;
        m_pend[w] = 1;
        m_pdata[w] = ref_mem[addr[w]];
      end
      m_run  = (m_owner < 0) ? 1 : m_run + 1;
      forced = lock[w] && req[o] && (m_run >= MAXB);
      if (lock[w] && !forced) m_owner = w;
      else begin
        m_owner = -1;
        m_run = 0;
      end
`ifdef RES_ARB_FIXED_PRIO_EN
      m_pref = (forced && w == 0) ? 1 : 0;
`else
      m_pref = o;
`endif
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a_gnt"},    a_gnt,    exp_g[0]);
    chk({tag, ".b_gnt"},    b_gnt,    exp_g[1]);
    chk({tag, ".res_rd"},   res_rd,   exp_rd);
    chk({tag, ".res_wr"},   res_wr,   exp_wr);
    chk({tag, ".res_addr"}, res_addr, m_addr);
    chk({tag, ".res_do"},   res_do,   m_do);
    chk({tag, ".a_rvalid"}, a_rvalid, m_rvalid[0]);
    chk({tag, ".b_rvalid"}, b_rvalid, m_rvalid[1]);
    chk({tag, ".a_rdata"},  a_rdata,  m_rdata[0]);
    chk({tag, ".b_rdata"},  b_rdata,  m_rdata[1]);
  endtask

  // One clock: predict, advance, check just after the edge.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic l,
                       input logic [13:0] ad, input logic [7:0] d);
    req[i] = r; wr[i] = w; lock[i] = l; addr[i] = ad; wdat[i] = d;
  endtask

  int wins[$];
  int bcount, first_a, cyc_n, a_at;
  logic [13:0] bnext;
  logic [13:0] prev_b_addr;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    model_reset();
    last_win = -1;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Write RAM[5]=1 from A, then B reads 5 on the very next cycle.
    drive(0, 1, 1, 0, 14'h0005, 8'h01);
    cyc("wr5");
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 1, 0, 0, 14'h0005, 8'h00);
    cyc("rd5");
    drive(1, 0, 0, 0, '0, '0);
    cyc("rd5_ret");
    chk("raw_rdata", b_rdata, 8'h01);
    chk("raw_rvalid", b_rvalid, 1'b1);

    // Continuous contention without lock.
    wins.delete();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 14'(i), 8'h00);
      drive(1, 1, 0, 0, 14'(100 + i), 8'h00);
      cyc("alt");
      wins.push_back(a_gnt ? 0 : (b_gnt ? 1 : 2));
    end
    for (int i = 1; i < 8; i++) begin
`ifdef RES_ARB_FIXED_PRIO_EN
      chk("alt_fixed", wins[i], 0);
`else
      chk("alt_rr", wins[i], 1 - wins[i-1]);
`endif
    end
    drive(1, 0, 0, 0, '0, '0);

    // Preload RAM[i]=i for the long burst test.
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, 0, 14'(i), 8'(i));
      cyc("preload");
    end
    drive(0, 0, 0, 0, '0, '0);

    // B locked burst of 10 with A waiting; lock dropped on the 11th grant.
    a_at = -1;
    for (int i = 1; i <= 12; i++) begin
      drive(0, i > 1, 0, 0, 14'h0040, 8'h00);
      drive(1, i <= 11, 0, i <= 10, 14'(32 + i), 8'h00);
      cyc("burst10");
      if (a_gnt && a_at < 0) a_at = i;
    end
    chk("burst10_a_first", a_at, 12);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    cyc("burst10_tail");

    // 300 locked B reads with A requesting: forced handoff after MAX_BURST grants.
    wins.delete();
    bcount = 0;
    bnext = '0;
    cyc_n = 0;
    while (bcount < 300 && cyc_n < 900) begin
      drive(0, (cyc_n > 0) && (cyc_n < 400), 0, 0, 14'h0100, 8'h00);
      drive(1, 1, 0, 1, bnext, 8'h00);
      cyc("burst300");
      if (b_rvalid) chk("b_rdata_addr", b_rdata, {prev_b_addr[7:0]});
      if (b_gnt) begin
        prev_b_addr = bnext;
        bnext++;
        bcount++;
      end
      if (a_gnt || b_gnt) wins.push_back(a_gnt ? 0 : 1);
      cyc_n++;
    end
    chk("burst300_done", bcount, 300);
    first_a = -1;
    for (int i = 0; i < wins.size(); i++) if (wins[i] == 0 && first_a < 0) first_a = i;
    chk("burst300_first_a", first_a, MAXB);
`ifndef RES_ARB_FIXED_PRIO_EN
    if (wins.size() > MAXB + 1) chk("burst300_b_resume", wins[MAXB + 1], 1);
    else chk("burst300_b_resume_len", wins.size(), MAXB + 2);
`endif
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    cyc("burst300_drain");

    // Reset between a read grant and its return.
    drive(0, 1, 0, 1, 14'h0007, 8'h00);
    cyc("rst_rd");
    drive(0, 0, 0, 0, '0, '0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1, 0, 0, 14'h0001, 8'h00);
    drive(1, 1, 0, 0, 14'h0002, 8'h00);
    cyc("rst_contend");
    chk("rst_a_wins", a_gnt, 1'b1);
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    cyc("rst_tail");

    // Random traffic on a small address window to exercise read-after-write.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++)
        drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, 14'($urandom_range(0, 15)), 8'($urandom));
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/res_ram_arbiter.md
# res_ram_arbiter

Two-requester arbiter and access sequencer for the single-port 16384×8 result RAM of the distance-transform (DT) datapath. It lets requester A (the binary-image loader that unpacks sti ROM words) and requester B (the forward/backward pass engine) share the one RAM port. It provides one access per cycle, a fixed read latency, and burst locking so that raster passes run without interleaving. It sits between those engines and the RAM's res_rd/res_wr/res_addr/res_do/res_di pins.

## Interface
- AW, 14: RAM address width (128×128 pixels).
- DW, 8: RAM data width.
- MAX_BURST, 128: maximum consecutive locked grants (one image row) before ownership is forced to the other requester.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- a_req, b_req  in  1  access request; held until the matching gnt
- a_wr, b_wr  in  1  1 = write, 0 = read; valid with req
- a_lock, b_lock  in  1  keep ownership after this access
- a_addr, b_addr  in  AW  pixel address
- a_wdata, b_wdata  in  DW  write data
- a_gnt, b_gnt  out  1  access accepted this cycle
- a_rvalid, b_rvalid  out  1  read data valid, single-cycle pulse
- a_rdata, b_rdata  out  DW  read data, held until the next rvalid of that requester
- res_rd  out  1  RAM read strobe
- res_wr  out  1  RAM write strobe
- res_addr  out  AW  RAM address
- res_do  out  DW  RAM write data
- res_di  in  DW  RAM read data; the RAM samples at negedge

## Operation
- State machine has three states: IDLE, OWN_A, OWN_B.
  - IDLE: no owner. On contention, the requester other than the last-granted one wins (round-robin). A single requester always wins.
  - A grant with lock=1 moves to OWN_x. A grant with lock=0 returns to or stays in IDLE.
  - OWN_x: only x can be granted. The other requester waits even while x is idle.
  - An OWN_x grant with lock=0 ends the burst and goes to IDLE.
- Burst counter:
  - Width is clog2(MAX_BURST)+1. It counts grants since ownership began and clears on IDLE.
  - On the MAX_BURST-th grant of a burst, the owner's lock is ignored if the other requester has req=1, and the state goes to IDLE with the other requester favoured.
  - If the other requester has req=0, the burst continues and the counter saturates.
- Per-grant behaviour:
  - Exactly one gnt is high, or none.
  - A read sets res_rd=1 and res_wr=0. A write sets res_wr=1 and res_rd=0. Both strobes are never high together.
  - res_addr/res_do are copied from the winner.
- Idle cycle: res_rd=res_wr=0, and res_addr/res_do hold their last values.
- wr, lock, addr and wdata are ignored while req=0.
- Read-after-write to the same address on back-to-back grants returns the new data. The RAM writes at posedge and reads at the following negedge; no extra logic is added.
- The read return tag is registered with the grant. rvalid goes to the requester that issued the read, even if ownership has changed since.

## Timing
- Reset (async, reset=0): all outputs are 0, state is IDLE, burst counter is 0, the round-robin pointer favours A, and any pending read return is discarded.
- Request sampled at rising edge k → gnt_x, res_* strobes, res_addr and res_do are registered at edge k and valid from k to k+1.
- Write: the RAM is updated at edge k+1.
- Read: res_di is captured at edge k+1. x_rvalid=1 and x_rdata are valid from k+1 to k+2. Latency is 1 cycle from gnt.
- Throughput is one access per cycle. A requester holding req=1 with a new addr after each gnt is served every cycle while it wins.
- A requester must not drop req before gnt. If it does, the request is simply not served; there is no error.
- Reset asserted mid-burst or mid-read clears everything at once. No rvalid is issued for the interrupted read.

## Configuration
- RES_ARB_FIXED_PRIO_EN defined: contention in IDLE always goes to A. Burst locking and the MAX_BURST forced handoff still apply.
- Not defined: round-robin as described above.

## Test plan
- Reset, then a_req=1, a_wr=1, a_addr=0x0005, a_wdata=0x01 → a_gnt at the next edge, res_wr=1 and res_addr=0x0005 for one cycle, and RAM[5]=0x01.
- b read of 0x0005 issued on the cycle right after that write → b_rvalid one cycle after b_gnt, with b_rdata=0x01.
- a_req=b_req=1 continuously with lock=0 → grants alternate A,B,A,B. With RES_ARB_FIXED_PRIO_EN: A on every cycle.
- b_lock=1 for 300 reads at addresses 0..299 while a_req=1 → B gets exactly 128 consecutive grants, then A gets one grant, then B resumes. Every B rdata matches its addr.
- b_lock=1 burst of 10 grants with a_req=1 throughout, then b_lock=0 on the 11th → A is not granted until the cycle after B's 11th grant.
- reset pulled low for one cycle between a read's gnt and its rvalid → no rvalid is seen, all outputs are 0, and the next grant goes to A on contention.
